pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Stage-1 fetch sequencer for the 3-stage pipeline. It owns the PC register and drives the select line of the next-PC mux (PC+4 vs. stage-2 ALU target). It handles boot from the reset vector, instruction-memory stalls, stage-2 redirects (branch/JAL/JALR), and redirects that arrive during a stall. It issues the instruction-memory request address and a kill flag that turns the wrong-path fetch into a bubble.

## Interface
Parameters:
- RESET_PC, 32'h0000_2000, PC loaded on reset; first fetch address.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- Stall  in  1  global stall (I/D-memory not ready); freezes PC
- Redirect_Valid  in  1  stage-2 control-transfer taken this cycle
- Redirect_Target  in  32  stage-2 ALU_Out target address
- PC_Sel  out  1  next-PC mux select; 0 = PC+4, 1 = ALU target
- PC_Out  out  32  current fetch PC (registered)
- PC_Next  out  32  mux output; value PC_Out takes at next unstalled edge
- IMem_Req  out  1  instruction-memory request valid
- IMem_Addr  out  32  instruction-memory address (= PC_Out)
- Inst_Kill  out  1  fetched instruction is wrong-path/boot; stage 1 inserts a NOP

## Operation
- States: BOOT, RUN, HELD (a redirect was captured while stalled).
- Reset (async, rst_n=0): state=BOOT, PC_Out=RESET_PC, Pend_Target=0, kill_q=1. Outputs: PC_Sel=0, IMem_Req=0, Inst_Kill=1.
- BOOT: IMem_Req=1 with IMem_Addr=RESET_PC, Inst_Kill=1. Redirect_Valid is ignored. If Stall=0, go to RUN and PC_Out←RESET_PC+4. If Stall=1, stay in BOOT.
- RUN, Stall=0:
  - PC_Sel=Redirect_Valid.
  - PC_Out←PC_Next.
  - kill_q←Redirect_Valid.
- RUN, Stall=1:
  - PC_Out is held.
  - If Redirect_Valid=1: Pend_Target←Redirect_Target, go to HELD.
  - Otherwise stay in RUN.
- HELD, Stall=1:
  - PC_Out is held.
  - A new Redirect_Valid overwrites Pend_Target (youngest redirect wins).
- HELD, Stall=0:
  - PC_Sel=1.
  - If Redirect_Valid=1, the mux target is Redirect_Target; otherwise it is Pend_Target.
  - PC_Out←target, kill_q←1, go to RUN.
- Inst_Kill=kill_q. kill_q holds its value while Stall=1, so the kill covers the response that finally returns.
- PC+4 uses 32-bit wrap-around: 32'hFFFF_FFFC+4 = 0.
- Targets are not alignment-checked. Bits [1:0] pass through unchanged.
- IMem_Req=1 in every state once rst_n=1.

## Timing
- PC_Sel and PC_Next are combinational from state, Stall, Redirect_Valid, Redirect_Target and Pend_Target. No registered path from redirect to PC_Sel.
- Redirect latency:
  - RUN: redirect in cycle N → PC_Out=target in cycle N+1 → Inst_Kill=1 in cycle N+1 only.
  - HELD: redirect is applied in the first cycle Stall=0, and PC_Out=target in the following cycle.
- Reset assertion mid-operation immediately forces the reset values, including dropping a pending target. Deassertion is synchronized externally. First fetch is the cycle after rst_n rises.
- Simultaneous Stall=1 and Redirect_Valid=1 in RUN: PC_Out does not change in that cycle.

## Structure
- Shared package stage1_control.vh holds:
  - PC_SEL_PC_4=1'b0, PC_SEL_ALU=1'b1
  - state encodings FETCH_BOOT=2'd0, FETCH_RUN=2'd1, FETCH_HELD=2'd2
  - RESET_PC default
- One sub-module: the existing PC_Mux, instantiated with:
  - PC_4=PC_Out+4
  - ALU_Out = (state==HELD && !Redirect_Valid) ? Pend_Target : Redirect_Target
  - PC_Sel
- The controller holds the state register, PC_Out, Pend_Target and kill_q.

## Test plan
- Reset, then release with Stall=0:
  - IMem_Addr sequence is 0x2000, 0x2004, 0x2008.
  - Inst_Kill=1 only on the 0x2000 cycle.
  - PC_Sel=0 throughout.
- Redirect_Valid=1, target 0x3000, in RUN at PC 0x2008: PC_Sel=1 that cycle, next PC_Out=0x3000 with Inst_Kill=1, then 0x3004 with Inst_Kill=0.
- Stall=1 for 3 cycles at PC 0x2010 with Redirect to 0x4000 in stall cycle 1:
  - PC_Out stays 0x2010.
  - State is HELD.
  - After Stall falls, PC_Out=0x4000 and Inst_Kill=1.
- HELD with pending 0x4000, then a new redirect to 0x5000 in the same cycle Stall falls: PC_Out=0x5000 (youngest wins).
- Boundary and reset cases:
  - PC_Out=0xFFFF_FFFC, no redirect: next PC_Out=0x0000_0000.
  - rst_n pulsed low mid-HELD: PC_Out=0x2000, state BOOT, Pend_Target cleared immediately (no clock edge needed).

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared stage-1 fetch definitions: next-PC mux select codes, fetch states, boot vector.
package pc_fetch_ctrl_pkg;

  localparam logic PC_SEL_PC_4 = 1'b0;
  localparam logic PC_SEL_ALU  = 1'b1;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_2000;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HELD = 2'd2
  } fetch_state_e;

  // Sequential fetch step; wraps at the top of the 32-bit space.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_pc_mux.sv
// Next-PC mux: sequential PC+4 or the stage-2 ALU target.
// Purely combinational, no state and no flow control.
module pc_fetch_ctrl_pc_mux
  import pc_fetch_ctrl_pkg::*;
(
  input  logic [31:0] pc_4,
  input  logic [31:0] alu_out,
  input  logic        pc_sel,
  output logic [31:0] pc_next
);

  assign pc_next = (pc_sel == PC_SEL_ALU) ? alu_out : pc_4;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Stage-1 fetch sequencer: owns the PC, handles boot, redirects and redirects parked under stall.
// Redirect reaches PC_Out one unstalled edge later; Stall freezes PC and the kill flag.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  output logic        PC_Sel,
  output logic [31:0] PC_Out,
  output logic [31:0] PC_Next,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  output logic        Inst_Kill
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_target_q, pend_target_d;
  logic         kill_q, kill_d;

  logic         pc_sel;
  logic [31:0]  pc_4;
  logic [31:0]  alu_out;
  logic [31:0]  pc_next;

  assign pc_4 = pc_plus4(pc_q);

  // A live redirect always beats the parked one.
  assign alu_out = (state_q == FETCH_HELD && !Redirect_Valid) ? pend_target_q : Redirect_Target;

  pc_fetch_ctrl_pc_mux u_pc_mux (
    .pc_4    (pc_4),
    .alu_out (alu_out),
    .pc_sel  (pc_sel),
    .pc_next (pc_next)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    kill_d        = kill_q;
    pc_sel        = PC_SEL_PC_4;

    unique case (state_q)
      FETCH_BOOT: begin
        if (!Stall) begin
          state_d = FETCH_RUN;
          pc_d    = pc_next;
          kill_d  = 1'b0;
        end
      end
      FETCH_RUN: begin
        pc_sel = Redirect_Valid ? PC_SEL_ALU : PC_SEL_PC_4;
        if (!Stall) begin
          pc_d   = pc_next;
          kill_d = Redirect_Valid;
        end else if (Redirect_Valid) begin
          pend_target_d = Redirect_Target;
          state_d       = FETCH_HELD;
        end
      end
      FETCH_HELD: begin
        pc_sel = PC_SEL_ALU;
        if (Stall) begin
          if (Redirect_Valid) begin
            pend_target_d = Redirect_Target;
          end
        end else begin
          pc_d    = pc_next;
          kill_d  = 1'b1;
          state_d = FETCH_RUN;
        end
      end
      default: begin
        state_d = FETCH_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH_BOOT;
      pc_q          <= RESET_PC;
      pend_target_q <= 32'd0;
      kill_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      kill_q        <= kill_d;
    end
  end

  assign PC_Sel    = pc_sel;
  assign PC_Out    = pc_q;
  assign PC_Next   = pc_next;
  assign IMem_Req  = rst_n;
  assign IMem_Addr = pc_q;
  assign Inst_Kill = kill_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: per-cycle stimulus rows push the expected post-edge PC/kill/state.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        Stall;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Target;
  logic        PC_Sel;
  logic [31:0] PC_Out;
  logic [31:0] PC_Next;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        Inst_Kill;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         stall;
    logic         rv;
    logic [31:0]  tgt;
    logic         exp_sel;
    logic [31:0]  exp_next;
    logic [31:0]  exp_pc;
    logic         exp_kill;
    fetch_state_e exp_st;
  } row_t;

  typedef struct {
    logic [31:0]  pc;
    logic         kill;
    fetch_state_e st;
  } exp_t;

  exp_t sb[$];

  pc_fetch_ctrl #(.RESET_PC(32'h0000_2000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Stall           (Stall),
    .Redirect_Valid  (Redirect_Valid),
    .Redirect_Target (Redirect_Target),
    .PC_Sel          (PC_Sel),
    .PC_Out          (PC_Out),
    .PC_Next         (PC_Next),
    .IMem_Req        (IMem_Req),
    .IMem_Addr       (IMem_Addr),
    .Inst_Kill       (Inst_Kill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    rst_n = 1'b0; Stall = 1'b0; Redirect_Valid = 1'b0; Redirect_Target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (PC_Out !== 32'h2000) begin errors++; $display("FAIL reset PC_Out: got %h want 00002000", PC_Out); end
    checks++; if (Inst_Kill !== 1'b1) begin errors++; $display("FAIL reset Inst_Kill: got %b want 1", Inst_Kill); end
    checks++; if (PC_Sel !== 1'b0) begin errors++; $display("FAIL reset PC_Sel: got %b want 0", PC_Sel); end
    checks++; if (IMem_Req !== 1'b0) begin errors++; $display("FAIL reset IMem_Req: got %b want 0", IMem_Req); end
    checks++; if (dut.state_q !== FETCH_BOOT) begin errors++; $display("FAIL reset state: got %0d want %0d", dut.state_q, FETCH_BOOT); end
    rst_n = 1'b1;
    #1;
    checks++; if (IMem_Req !== 1'b1 || IMem_Addr !== 32'h2000) begin errors++; $display("FAIL boot_req: req=%b addr=%h want 1/00002000", IMem_Req, IMem_Addr); end
    checks++; if (PC_Next !== 32'h2004) begin errors++; $display("FAIL boot_next: got %h want 00002004", PC_Next); end
  endtask

  task automatic test_boot_run();
    row_t rows [0:1];
    exp_t e;
    rows = '{
      '{1'b0, 1'b0, 32'h0, 1'b0, 32'h2004, 32'h2004, 1'b0, FETCH_RUN},
      '{1'b0, 1'b0, 32'h0, 1'b0, 32'h2008, 32'h2008, 1'b0, FETCH_RUN}
    };
    foreach (rows[i]) begin
      Stall = rows[i].stall; Redirect_Valid = rows[i].rv; Redirect_Target = rows[i].tgt;
      sb.push_back('{rows[i].exp_pc, rows[i].exp_kill, rows[i].exp_st});
      #1;
      checks++; if (PC_Sel !== rows[i].exp_sel) begin errors++; $display("FAIL boot_run[%0d] PC_Sel: got %b want %b", i, PC_Sel, rows[i].exp_sel); end
      checks++; if (PC_Next !== rows[i].exp_next) begin errors++; $display("FAIL boot_run[%0d] PC_Next: got %h want %h", i, PC_Next, rows[i].exp_next); end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (PC_Out !== e.pc || IMem_Addr !== e.pc) begin errors++; $display("FAIL boot_run[%0d] PC_Out: got %h/%h want %h", i, PC_Out, IMem_Addr, e.pc); end
      checks++; if (Inst_Kill !== e.kill) begin errors++; $display("FAIL boot_run[%0d] Inst_Kill: got %b want %b", i, Inst_Kill, e.kill); end
      checks++; if (dut.state_q !== e.st) begin errors++; $display("FAIL boot_run[%0d] state: got %0d want %0d", i, dut.state_q, e.st); end
    end
  endtask

  task automatic test_redirect_run();
    row_t rows [0:2];
    exp_t e;
    rows = '{
      '{1'b0, 1'b1, 32'h3000, 1'b1, 32'h3000, 32'h3000, 1'b1, FETCH_RUN},
      '{1'b0, 1'b0, 32'h0,    1'b0, 32'h3004, 32'h3004, 1'b0, FETCH_RUN},
      '{1'b0, 1'b1, 32'h2010, 1'b1, 32'h2010, 32'h2010, 1'b1, FETCH_RUN}
    };
    foreach (rows[i]) begin
      Stall = rows[i].stall; Redirect_Valid = rows[i].rv; Redirect_Target = rows[i].tgt;
      sb.push_back('{rows[i].exp_pc, rows[i].exp_kill, rows[i].exp_st});
      #1;
      checks++; if (PC_Sel !== rows[i].exp_sel) begin errors++; $display("FAIL redirect_run[%0d] PC_Sel: got %b want %b", i, PC_Sel, rows[i].exp_sel); end
      checks++; if (PC_Next !== rows[i].exp_next) begin errors++; $display("FAIL redirect_run[%0d] PC_Next: got %h want %h", i, PC_Next, rows[i].exp_next); end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (PC_Out !== e.pc || IMem_Addr !== e.pc) begin errors++; $display("FAIL redirect_run[%0d] PC_Out: got %h/%h want %h", i, PC_Out, IMem_Addr, e.pc); end
      checks++; if (Inst_Kill !== e.kill) begin errors++; $display("FAIL redirect_run[%0d] Inst_Kill: got %b want %b", i, Inst_Kill, e.kill); end
      checks++; if (dut.state_q !== e.st) begin errors++; $display("FAIL redirect_run[%0d] state: got %0d want %0d", i, dut.state_q, e.st); end
    end
  endtask

  task automatic test_stall_redirect();
    row_t rows [0:6];
    exp_t e;
    rows = '{
      '{1'b1, 1'b1, 32'h4000, 1'b1, 32'h4000, 32'h2010, 1'b1, FETCH_HELD},
      '{1'b1, 1'b0, 32'h0,    1'b1, 32'h4000, 32'h2010, 1'b1, FETCH_HELD},
      '{1'b1, 1'b0, 32'h0,    1'b1, 32'h4000, 32'h2010, 1'b1, FETCH_HELD},
      '{1'b0, 1'b0, 32'h0,    1'b1, 32'h4000, 32'h4000, 1'b1, FETCH_RUN},
      '{1'b0, 1'b0, 32'h0,    1'b0, 32'h4004, 32'h4004, 1'b0, FETCH_RUN},
      '{1'b1, 1'b0, 32'h0,    1'b0, 32'h4008, 32'h4004, 1'b0, FETCH_RUN},
      '{1'b0, 1'b0, 32'h0,    1'b0, 32'h4008, 32'h4008, 1'b0, FETCH_RUN}
    };
    foreach (rows[i]) begin
      Stall = rows[i].stall; Redirect_Valid = rows[i].rv; Redirect_Target = rows[i].tgt;
      sb.push_back('{rows[i].exp_pc, rows[i].exp_kill, rows[i].exp_st});
      #1;
      checks++; if (PC_Sel !== rows[i].exp_sel) begin errors++; $display("FAIL stall_redirect[%0d] PC_Sel: got %b want %b", i, PC_Sel, rows[i].exp_sel); end
      checks++; if (PC_Next !== rows[i].exp_next) begin errors++; $display("FAIL stall_redirect[%0d] PC_Next: got %h want %h", i, PC_Next, rows[i].exp_next); end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (PC_Out !== e.pc || IMem_Addr !== e.pc) begin errors++; $display("FAIL stall_redirect[%0d] PC_Out: got %h/%h want %h", i, PC_Out, IMem_Addr, e.pc); end
      checks++; if (Inst_Kill !== e.kill) begin errors++; $display("FAIL stall_redirect[%0d] Inst_Kill: got %b want %b", i, Inst_Kill, e.kill); end
      checks++; if (dut.state_q !== e.st) begin errors++; $display("FAIL stall_redirect[%0d] state: got %0d want %0d", i, dut.state_q, e.st); end
    end
  endtask

  task automatic test_youngest_wins();
    row_t rows [0:4];
    exp_t e;
    rows = '{
      '{1'b1, 1'b1, 32'h4000, 1'b1, 32'h4000, 32'h4008, 1'b0, FETCH_HELD},
      '{1'b1, 1'b1, 32'h6000, 1'b1, 32'h6000, 32'h4008, 1'b0, FETCH_HELD},
      '{1'b1, 1'b0, 32'h0,    1'b1, 32'h6000, 32'h4008, 1'b0, FETCH_HELD},
      '{1'b0, 1'b1, 32'h5000, 1'b1, 32'h5000, 32'h5000, 1'b1, FETCH_RUN},
      '{1'b0, 1'b0, 32'h0,    1'b0, 32'h5004, 32'h5004, 1'b0, FETCH_RUN}
    };
    foreach (rows[i]) begin
      Stall = rows[i].stall; Redirect_Valid = rows[i].rv; Redirect_Target = rows[i].tgt;
      sb.push_back('{rows[i].exp_pc, rows[i].exp_kill, rows[i].exp_st});
      #1;
      checks++; if (PC_Sel !== rows[i].exp_sel) begin errors++; $display("FAIL youngest[%0d] PC_Sel: got %b want %b", i, PC_Sel, rows[i].exp_sel); end
      checks++; if (PC_Next !== rows[i].exp_next) begin errors++; $display("FAIL youngest[%0d] PC_Next: got %h want %h", i, PC_Next, rows[i].exp_next); end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (PC_Out !== e.pc || IMem_Addr !== e.pc) begin errors++; $display("FAIL youngest[%0d] PC_Out: got %h/%h want %h", i, PC_Out, IMem_Addr, e.pc); end
      checks++; if (Inst_Kill !== e.kill) begin errors++; $display("FAIL youngest[%0d] Inst_Kill: got %b want %b", i, Inst_Kill, e.kill); end
      checks++; if (dut.state_q !== e.st) begin errors++; $display("FAIL youngest[%0d] state: got %0d want %0d", i, dut.state_q, e.st); end
    end
  endtask

  task automatic test_wrap_unaligned();
    row_t rows [0:4];
    exp_t e;
    rows = '{
      '{1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b1, FETCH_RUN},
      '{1'b0, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, FETCH_RUN},
      '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, FETCH_RUN},
      '{1'b0, 1'b1, 32'h0000_1233, 1'b1, 32'h0000_1233, 32'h0000_1233, 1'b1, FETCH_RUN},
      '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_1237, 32'h0000_1237, 1'b0, FETCH_RUN}
    };
    foreach (rows[i]) begin
      Stall = rows[i].stall; Redirect_Valid = rows[i].rv; Redirect_Target = rows[i].tgt;
      sb.push_back('{rows[i].exp_pc, rows[i].exp_kill, rows[i].exp_st});
      #1;
      checks++; if (PC_Sel !== rows[i].exp_sel) begin errors++; $display("FAIL wrap[%0d] PC_Sel: got %b want %b", i, PC_Sel, rows[i].exp_sel); end
      checks++; if (PC_Next !== rows[i].exp_next) begin errors++; $display("FAIL wrap[%0d] PC_Next: got %h want %h", i, PC_Next, rows[i].exp_next); end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (PC_Out !== e.pc || IMem_Addr !== e.pc) begin errors++; $display("FAIL wrap[%0d] PC_Out: got %h/%h want %h", i, PC_Out, IMem_Addr, e.pc); end
      checks++; if (Inst_Kill !== e.kill) begin errors++; $display("FAIL wrap[%0d] Inst_Kill: got %b want %b", i, Inst_Kill, e.kill); end
      checks++; if (dut.state_q !== e.st) begin errors++; $display("FAIL wrap[%0d] state: got %0d want %0d", i, dut.state_q, e.st); end
    end
  endtask

  task automatic test_reset_mid_held();
    row_t rows [0:2];
    exp_t e;
    Stall = 1'b1; Redirect_Valid = 1'b1; Redirect_Target = 32'h7000;
    @(posedge clk); #1;
    Redirect_Valid = 1'b0;
    checks++; if (dut.state_q !== FETCH_HELD) begin errors++; $display("FAIL mid_held state: got %0d want %0d", dut.state_q, FETCH_HELD); end
    checks++; if (dut.pend_target_q !== 32'h7000) begin errors++; $display("FAIL mid_held pend: got %h want 00007000", dut.pend_target_q); end
    // Async reset, sampled well before the next clock edge.
    rst_n = 1'b0;
    #1;
    checks++; if (PC_Out !== 32'h2000) begin errors++; $display("FAIL async_reset PC_Out: got %h want 00002000", PC_Out); end
    checks++; if (dut.state_q !== FETCH_BOOT) begin errors++; $display("FAIL async_reset state: got %0d want %0d", dut.state_q, FETCH_BOOT); end
    checks++; if (dut.pend_target_q !== 32'h0) begin errors++; $display("FAIL async_reset pend: got %h want 00000000", dut.pend_target_q); end
    checks++; if (Inst_Kill !== 1'b1 || IMem_Req !== 1'b0 || PC_Sel !== 1'b0) begin errors++; $display("FAIL async_reset outs: kill=%b req=%b sel=%b want 1/0/0", Inst_Kill, IMem_Req, PC_Sel); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rows = '{
      '{1'b1, 1'b0, 32'h0,    1'b0, 32'h2004, 32'h2000, 1'b1, FETCH_BOOT},
      '{1'b0, 1'b1, 32'h9000, 1'b0, 32'h2004, 32'h2004, 1'b0, FETCH_RUN},
      '{1'b0, 1'b0, 32'h0,    1'b0, 32'h2008, 32'h2008, 1'b0, FETCH_RUN}
    };
    foreach (rows[i]) begin
      Stall = rows[i].stall; Redirect_Valid = rows[i].rv; Redirect_Target = rows[i].tgt;
      sb.push_back('{rows[i].exp_pc, rows[i].exp_kill, rows[i].exp_st});
      #1;
      checks++; if (PC_Sel !== rows[i].exp_sel) begin errors++; $display("FAIL reboot[%0d] PC_Sel: got %b want %b", i, PC_Sel, rows[i].exp_sel); end
      checks++; if (PC_Next !== rows[i].exp_next) begin errors++; $display("FAIL reboot[%0d] PC_Next: got %h want %h", i, PC_Next, rows[i].exp_next); end
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++; if (PC_Out !== e.pc || IMem_Addr !== e.pc) begin errors++; $display("FAIL reboot[%0d] PC_Out: got %h/%h want %h", i, PC_Out, IMem_Addr, e.pc); end
      checks++; if (Inst_Kill !== e.kill) begin errors++; $display("FAIL reboot[%0d] Inst_Kill: got %b want %b", i, Inst_Kill, e.kill); end
      checks++; if (dut.state_q !== e.st) begin errors++; $display("FAIL reboot[%0d] state: got %0d want %0d", i, dut.state_q, e.st); end
    end
  endtask

  initial begin
    test_reset();
    test_boot_run();
    test_redirect_run();
    test_stall_redirect();
    test_youngest_wins();
    test_wrap_unaligned();
    test_reset_mid_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
